// File: rtl/orv64_typedef_pkg.sv
// Shared orv64 types for the debug halt controller.
//   orv64_halt_state_e : halt controller FSM states
//   orv64_halt_cause_e : reason for the current/last halt, reported to the debug module
package orv64_typedef_pkg;

    typedef enum logic [1:0] {
        ORV64_HALT_RUN  = 2'd0,
        ORV64_HALT_PEND = 2'd1,
        ORV64_HALTED    = 2'd2,
        ORV64_HALT_STEP = 2'd3
    } orv64_halt_state_e;

    typedef enum logic [1:0] {
        ORV64_CAUSE_NONE       = 2'd0,
        ORV64_CAUSE_BREAKPOINT = 2'd1,
        ORV64_CAUSE_DEBUG_REQ  = 2'd2,
        ORV64_CAUSE_STEP       = 2'd3
    } orv64_halt_cause_e;

    localparam logic [31:0] ORV64_HALT_CYCLES_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/orv64_halt_ctrl.sv
// Debug halt controller for the orv64 core.
// Takes the breakpoint stall level and debug-module requests and runs the
// halt / resume / single-step handshake against the pipeline.
//
// Ports:
//   clk, rst_n         core clock, synchronous active-low reset
//   bp_stall           breakpoint match level
//   dbg_halt_req       halt request level from the debug module
//   dbg_resume_req     one-cycle resume pulse
//   dbg_step_req       one-cycle step pulse, qualifies dbg_step_cnt
//   dbg_step_cnt       instructions to retire per step
//   wb_valid           instruction retired this cycle
//   pipe_drained       pipeline empty and frozen
//   pipe_halt          hold fetch / drain pipeline
//   pipe_resume        one-cycle restart pulse
//   halted, halt_ack   halt status and entry pulse
//   halt_cause         NONE / BREAKPOINT / DEBUG_REQ / STEP
//   halt_cycles        saturating length of current/last HALTED episode
//   step_remaining     retirements left in the active step
//
// state     | meaning
// ----------+-----------------------------------------------
// RUN       | core executing normally
// HALT_PEND | fetch held, waiting for the pipeline to drain
// HALTED    | core frozen, counting halted cycles
// STEP      | executing a bounded number of retirements
module orv64_halt_ctrl
    import orv64_typedef_pkg::*;
#(
    parameter int unsigned STEP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bp_stall,
    input  logic                  dbg_halt_req,
    input  logic                  dbg_resume_req,
    input  logic                  dbg_step_req,
    input  logic [STEP_CNT_W-1:0] dbg_step_cnt,
    input  logic                  wb_valid,
    input  logic                  pipe_drained,
    output logic                  pipe_halt,
    output logic                  pipe_resume,
    output logic                  halted,
    output logic                  halt_ack,
    output logic [1:0]            halt_cause,
    output logic [31:0]           halt_cycles,
    output logic [STEP_CNT_W-1:0] step_remaining
);

    orv64_halt_state_e     r_state;
    orv64_halt_cause_e     r_cause;
    logic                  r_bp_mask;
    logic                  r_pipe_resume;
    logic                  r_halt_ack;
    logic [31:0]           r_halt_cycles;
    logic [STEP_CNT_W-1:0] r_step_rem;

    logic                  w_bp_eff;
    logic                  w_halt_src;
    logic                  w_do_resume;
    logic                  w_do_step;
    logic                  w_step_last;
    orv64_halt_cause_e     w_src_cause;

    // The mask keeps the breakpoint that caused the halt from re-firing
    // until the instruction it matched has actually retired.
    assign w_bp_eff    = bp_stall & ~r_bp_mask;
    assign w_halt_src  = dbg_halt_req | w_bp_eff;
    assign w_src_cause = dbg_halt_req ? ORV64_CAUSE_DEBUG_REQ : ORV64_CAUSE_BREAKPOINT;

    // A held halt request blocks both resume and step; resume beats step.
    assign w_do_resume = (r_state == ORV64_HALTED) & dbg_resume_req & ~dbg_halt_req;
    assign w_do_step   = (r_state == ORV64_HALTED) & ~dbg_resume_req & dbg_step_req
                       & ~dbg_halt_req & (dbg_step_cnt != '0);
    assign w_step_last = wb_valid & (r_step_rem == STEP_CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ORV64_HALT_RUN;
            r_cause       <= ORV64_CAUSE_NONE;
            r_bp_mask     <= 1'b0;
            r_pipe_resume <= 1'b0;
            r_halt_ack    <= 1'b0;
            r_halt_cycles <= '0;
            r_step_rem    <= '0;
        end else begin
            r_pipe_resume <= w_do_resume | w_do_step;
            r_halt_ack    <= 1'b0;

            if (w_do_resume | w_do_step) begin
                r_bp_mask <= 1'b1;
            end else if (wb_valid) begin
                r_bp_mask <= 1'b0;
            end

            case (r_state)
                ORV64_HALT_RUN: begin
                    if (w_halt_src) begin
                        r_state <= ORV64_HALT_PEND;
                        r_cause <= w_src_cause;
                    end
                end
                ORV64_HALT_PEND: begin
                    if (pipe_drained) begin
                        r_state       <= ORV64_HALTED;
                        r_halt_ack    <= 1'b1;
                        r_halt_cycles <= '0;
                    end
                end
                ORV64_HALTED: begin
                    if (r_halt_cycles != ORV64_HALT_CYCLES_MAX) begin
                        r_halt_cycles <= r_halt_cycles + 32'd1;
                    end
                    if (w_do_resume) begin
                        r_state <= ORV64_HALT_RUN;
                        r_cause <= ORV64_CAUSE_NONE;
                    end else if (w_do_step) begin
                        r_state    <= ORV64_HALT_STEP;
                        r_cause    <= ORV64_CAUSE_NONE;
                        r_step_rem <= dbg_step_cnt;
                    end
                end
                ORV64_HALT_STEP: begin
                    // A retirement coinciding with a halt source is still
                    // counted; finishing the step wins unless debug asked.
                    if (w_halt_src | w_step_last) begin
                        r_state    <= ORV64_HALT_PEND;
                        r_step_rem <= '0;
                        r_cause    <= (w_step_last & ~dbg_halt_req) ? ORV64_CAUSE_STEP
                                                                    : w_src_cause;
                    end else if (wb_valid) begin
                        r_step_rem <= r_step_rem - STEP_CNT_W'(1);
                    end
                end
                default: r_state <= ORV64_HALT_RUN;
            endcase
        end
    end

    assign pipe_halt      = (r_state == ORV64_HALT_PEND) | (r_state == ORV64_HALTED);
    assign halted         = (r_state == ORV64_HALTED);
    assign pipe_resume    = r_pipe_resume;
    assign halt_ack       = r_halt_ack;
    assign halt_cause     = r_cause;
    assign halt_cycles    = r_halt_cycles;
    assign step_remaining = r_step_rem;

endmodule

// File: tb/tb_orv64_halt_ctrl.sv
module tb_orv64_halt_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         bp_stall, dbg_halt_req, dbg_resume_req, dbg_step_req;
    logic [W-1:0] dbg_step_cnt;
    logic         wb_valid, pipe_drained;
    logic         pipe_halt, pipe_resume, halted, halt_ack;
    logic [1:0]   halt_cause;
    logic [31:0]  halt_cycles;
    logic [W-1:0] step_remaining;

    int checks = 0;
    int errors = 0;

    orv64_halt_ctrl #(.STEP_CNT_W(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bp_stall       (bp_stall),
        .dbg_halt_req   (dbg_halt_req),
        .dbg_resume_req (dbg_resume_req),
        .dbg_step_req   (dbg_step_req),
        .dbg_step_cnt   (dbg_step_cnt),
        .wb_valid       (wb_valid),
        .pipe_drained   (pipe_drained),
        .pipe_halt      (pipe_halt),
        .pipe_resume    (pipe_resume),
        .halted         (halted),
        .halt_ack       (halt_ack),
        .halt_cause     (halt_cause),
        .halt_cycles    (halt_cycles),
        .step_remaining (step_remaining)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the core is either running, draining, halted or
    // stepping (steps_left > 0); halted cycles are a saturating tally.
    bit          m_draining = 0, m_halted = 0, m_mask = 0, m_resume = 0, m_ack = 0;
    int          m_cause = 0;
    int          m_steps = 0;
    logic [31:0] m_hc = 0;
    bit          cmp_en = 0;
    bit          skip_hc = 0;

    always @(posedge clk) begin
        bit src, leave;
        int left;
        if (!rst_n) begin
            m_draining = 0; m_halted = 0; m_mask = 0; m_resume = 0; m_ack = 0;
            m_cause = 0; m_steps = 0; m_hc = 0;
        end else begin
            src = dbg_halt_req | (bp_stall & ~m_mask);
            leave = 0;
            m_resume = 0;
            m_ack = 0;
            if (m_halted) begin
                if (m_hc != 32'hFFFF_FFFF) m_hc = m_hc + 1;
                if (!dbg_halt_req && dbg_resume_req) begin
                    m_halted = 0; leave = 1; m_cause = 0;
                end else if (!dbg_halt_req && dbg_step_req && dbg_step_cnt != 0) begin
                    m_halted = 0; leave = 1; m_cause = 0; m_steps = int'(dbg_step_cnt);
                end
            end else if (m_draining) begin
                if (pipe_drained) begin
                    m_draining = 0; m_halted = 1; m_hc = 0; m_ack = 1;
                end
            end else if (m_steps > 0) begin
                left = m_steps - (wb_valid ? 1 : 0);
                if (src || left == 0) begin
                    m_draining = 1;
                    m_steps = 0;
                    if (left == 0 && !dbg_halt_req) m_cause = 3;
                    else m_cause = dbg_halt_req ? 2 : 1;
                end else begin
                    m_steps = left;
                end
            end else if (src) begin
                m_draining = 1;
                m_cause = dbg_halt_req ? 2 : 1;
            end
            m_resume = leave;
            if (leave) m_mask = 1;
            else if (wb_valid) m_mask = 0;
            if (skip_hc) m_hc = 32'hFFFF_FFFF;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_pipe_halt", {31'd0, pipe_halt}, {31'd0, m_draining | m_halted});
            chk("m_halted", {31'd0, halted}, {31'd0, m_halted});
            chk("m_pipe_resume", {31'd0, pipe_resume}, {31'd0, m_resume});
            chk("m_halt_ack", {31'd0, halt_ack}, {31'd0, m_ack});
            chk("m_halt_cause", {30'd0, halt_cause}, 32'(m_cause));
            chk("m_step_remaining", {16'd0, step_remaining}, 32'(m_steps));
            if (!skip_hc) chk("m_halt_cycles", halt_cycles, m_hc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        pipe_drained = 1; tick(1); pipe_drained = 0;
    endtask

    task automatic dbg_halt_pulse();
        dbg_halt_req = 1; tick(1); dbg_halt_req = 0;
    endtask

    task automatic resume_pulse();
        dbg_resume_req = 1; tick(1); dbg_resume_req = 0;
    endtask

    task automatic step_pulse(input int cnt);
        dbg_step_req = 1; dbg_step_cnt = W'(cnt); tick(1); dbg_step_req = 0; dbg_step_cnt = '0;
    endtask

    task automatic retire();
        wb_valid = 1; tick(1); wb_valid = 0;
    endtask

    initial begin
        rst_n = 0; bp_stall = 0; dbg_halt_req = 0; dbg_resume_req = 0; dbg_step_req = 0;
        dbg_step_cnt = '0; wb_valid = 0; pipe_drained = 0;
        tick(3);
        cmp_en = 1;
        chk("rst_pipe_halt", {31'd0, pipe_halt}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cause", {30'd0, halt_cause}, 32'd0);
        chk("rst_halt_cycles", halt_cycles, 32'd0);
        rst_n = 1;
        tick(2);

        // Breakpoint halt; pipe_drained pulsed outside HALT_PEND is ignored
        pipe_drained = 1; tick(1); pipe_drained = 0;
        chk("bp_no_spurious", {31'd0, halted}, 32'd0);
        bp_stall = 1; tick(1); bp_stall = 0;
        chk("bp_pipe_halt_n1", {31'd0, pipe_halt}, 32'd1);
        chk("bp_cause_n1", {30'd0, halt_cause}, 32'd1);
        tick(3);
        chk("bp_still_pending", {31'd0, halted}, 32'd0);
        drain();
        chk("bp_halted", {31'd0, halted}, 32'd1);
        chk("bp_halt_ack", {31'd0, halt_ack}, 32'd1);
        tick(1);
        chk("bp_ack_one_cycle", {31'd0, halt_ack}, 32'd0);
        chk("bp_hc_1", halt_cycles, 32'd1);

        // Resume past a still-matching breakpoint
        bp_stall = 1;
        resume_pulse();
        chk("res_pulse", {31'd0, pipe_resume}, 32'd1);
        chk("res_not_halted", {31'd0, pipe_halt}, 32'd0);
        chk("res_cause_none", {30'd0, halt_cause}, 32'd0);
        chk("res_hc_held", halt_cycles, 32'd2);
        tick(2);
        chk("res_no_rehalt", {31'd0, pipe_halt}, 32'd0);
        retire();
        chk("res_mask_clear_cycle", {31'd0, pipe_halt}, 32'd0);
        tick(1);
        chk("res_rehalt", {31'd0, pipe_halt}, 32'd1);
        bp_stall = 0;
        drain();

        // Single step of 3
        step_pulse(3);
        chk("st_rem3", {16'd0, step_remaining}, 32'd3);
        chk("st_resume", {31'd0, pipe_resume}, 32'd1);
        retire();
        chk("st_rem2", {16'd0, step_remaining}, 32'd2);
        tick(1);
        retire();
        chk("st_rem1", {16'd0, step_remaining}, 32'd1);
        retire();
        chk("st_rem0", {16'd0, step_remaining}, 32'd0);
        chk("st_pend", {31'd0, pipe_halt & ~halted}, 32'd1);
        chk("st_cause", {30'd0, halt_cause}, 32'd3);
        drain();

        // Step preemption by debug request after 2 retirements
        step_pulse(5);
        retire();
        retire();
        dbg_halt_req = 1; tick(1);
        chk("pre_cause", {30'd0, halt_cause}, 32'd2);
        chk("pre_rem", {16'd0, step_remaining}, 32'd0);
        drain();
        resume_pulse();
        chk("held_ignores_resume", {31'd0, halted}, 32'd1);
        dbg_halt_req = 0;
        step_pulse(0);
        chk("step0_halted", {31'd0, halted}, 32'd1);
        chk("step0_no_resume", {31'd0, pipe_resume}, 32'd0);

        // Resume and step together: resume wins
        dbg_step_req = 1; dbg_step_cnt = W'(4); resume_pulse();
        dbg_step_req = 0; dbg_step_cnt = '0;
        chk("rs_rem", {16'd0, step_remaining}, 32'd0);
        chk("rs_running", {31'd0, pipe_halt}, 32'd0);

        // Step ending on the same cycle as a breakpoint: cause STEP
        dbg_halt_pulse(); drain();
        step_pulse(2);
        retire();
        bp_stall = 1; retire(); bp_stall = 0;
        chk("st_bp_cause", {30'd0, halt_cause}, 32'd3);
        drain();

        // Step ending with a debug request: cause DEBUG_REQ
        step_pulse(1);
        dbg_halt_req = 1; retire(); dbg_halt_req = 0;
        chk("st_dbg_cause", {30'd0, halt_cause}, 32'd2);
        drain();

        // 100 halted cycles
        resume_pulse();
        dbg_halt_pulse(); drain();
        tick(99);
        resume_pulse();
        chk("hc_100", halt_cycles, 32'd100);
        tick(5);
        chk("hc_100_held", halt_cycles, 32'd100);

        // Saturation
        dbg_halt_pulse(); drain();
        skip_hc = 1;
        force dut.r_halt_cycles = 32'hFFFF_FFF0;
        tick(1);
        release dut.r_halt_cycles;
        tick(30);
        skip_hc = 0;
        tick(1);
        chk("hc_sat", halt_cycles, 32'hFFFF_FFFF);
        tick(3);
        resume_pulse();
        chk("hc_sat_held", halt_cycles, 32'hFFFF_FFFF);

        // Reset during HALT_PEND
        dbg_halt_req = 1; tick(1); dbg_halt_req = 0;
        chk("rp_pending", {31'd0, pipe_halt}, 32'd1);
        rst_n = 0; tick(1);
        chk("rp_pipe_halt", {31'd0, pipe_halt}, 32'd0);
        chk("rp_cause", {30'd0, halt_cause}, 32'd0);
        chk("rp_hc", halt_cycles, 32'd0);
        rst_n = 1;
        tick(1);

        // Simultaneous sources
        dbg_halt_req = 1; bp_stall = 1; tick(1); dbg_halt_req = 0; bp_stall = 0;
        chk("sim_cause", {30'd0, halt_cause}, 32'd2);
        drain();
        tick(2);

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/orv64_halt_ctrl.md
# orv64_halt_ctrl

Debug halt controller for the orv64 core, directly downstream of the breakpoint unit. It consumes the level `bp_stall` plus external debug requests and runs a halt/resume/step state machine against the pipeline. It drives the pipeline halt/resume handshake and reports halt status, cause, step progress and halted-cycle count to the debug module.

## Interface
- `STEP_CNT_W`, default 16: width of the single-step instruction count.
- `clk`  in  1  core clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `bp_stall`  in  1  level from breakpoint unit; PC or instret match.
- `dbg_halt_req`  in  1  level halt request from debug module.
- `dbg_resume_req`  in  1  one-cycle resume pulse.
- `dbg_step_req`  in  1  one-cycle step pulse.
- `dbg_step_cnt`  in  STEP_CNT_W  instructions to retire per step; sampled with `dbg_step_req`.
- `wb_valid`  in  1  instruction retired this cycle.
- `pipe_drained`  in  1  pipeline empty and frozen under `pipe_halt`.
- `pipe_halt`  out  1  hold fetch and drain the pipeline.
- `pipe_resume`  out  1  one-cycle restart pulse to the pipeline.
- `halted`  out  1  core is halted.
- `halt_ack`  out  1  one-cycle pulse on entry to HALTED.
- `halt_cause`  out  2  0 NONE, 1 BREAKPOINT, 2 DEBUG_REQ, 3 STEP.
- `halt_cycles`  out  32  cycles spent in the current or last HALTED episode; saturating.
- `step_remaining`  out  STEP_CNT_W  instructions left in the active step.

## Operation
- States: RUN, HALT_PEND, HALTED, STEP.
- `bp_eff = bp_stall & ~bp_mask`.
- The halt source is `dbg_halt_req | bp_eff`. If both are present in the same cycle, the cause is DEBUG_REQ.
- RUN:
  - On a halt source, go to HALT_PEND and latch the cause.
- HALT_PEND:
  - `pipe_halt` = 1.
  - When `pipe_drained` = 1, go to HALTED.
  - `wb_valid` is ignored (drain retirements).
- HALTED:
  - `pipe_halt` = 1, `halted` = 1.
  - `halt_cycles` increments each cycle and saturates at 0xFFFF_FFFF.
  - `dbg_resume_req & ~dbg_halt_req`: go to RUN, pulse `pipe_resume`, set `bp_mask`, set `halt_cause` to NONE.
  - `dbg_step_req & ~dbg_halt_req & dbg_step_cnt != 0`: go to STEP, load `step_remaining = dbg_step_cnt`, pulse `pipe_resume`, set `bp_mask`.
  - A step with count 0 is ignored.
  - If resume and step arrive together, resume wins and step is dropped.
- STEP:
  - Each `wb_valid` decrements `step_remaining`.
  - When `wb_valid` arrives with `step_remaining` = 1, go to HALT_PEND with cause STEP.
  - A halt source preempts: go to HALT_PEND with the corresponding cause and clear `step_remaining` to 0.
  - A retirement on the same cycle as a halt source still decrements first. If that decrement reaches 0, the cause is STEP unless `dbg_halt_req` is set.
- `bp_mask` is cleared on the first `wb_valid` after it is set. This stops the still-matching breakpoint from re-halting before the halted instruction retires.
- `halt_cycles` clears to 0 on entry to HALTED and holds its value outside HALTED.

## Timing
- Reset (`rst_n` = 0 at a clock edge), from any state:
  - state goes to RUN;
  - all outputs are 0;
  - `bp_mask` is 0, `step_remaining` is 0, `halt_cycles` is 0.
- Outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- Halt source at cycle N gives `pipe_halt` = 1 at N+1.
- `pipe_drained` sampled high at cycle M in HALT_PEND gives `halted` = 1 and a one-cycle `halt_ack` at M+1. `halt_cause` is valid from N+1 and stable until the next resume or step.
- Resume or step pulse at cycle K gives `pipe_resume` = 1 for cycle K+1 only, and `pipe_halt` = 0 and `halted` = 0 at K+1.
- `pipe_drained` is ignored outside HALT_PEND.
- `dbg_halt_req` held high while HALTED keeps the core halted; resume and step are ignored.

## Structure
- Add `orv64_halt_state_e` (RUN, HALT_PEND, HALTED, STEP) and `orv64_halt_cause_e` (2-bit encoding above) to `orv64_typedef_pkg`.
- Single module, no sub-module. Counters and the FSM are inline.

## Test plan
- **Breakpoint halt:** `bp_stall` = 1 at cycle 10, `pipe_drained` = 1 at cycle 14 -> `pipe_halt` = 1 at 11, `halted` = 1 and `halt_ack` pulse at 15, `halt_cause` = 1.
- **Resume past breakpoint:** resume from HALTED with `bp_stall` held high -> `pipe_resume` pulse and no re-halt. On the next cycle with `wb_valid` = 1, `bp_mask` clears, and `bp_stall` still high then gives HALT_PEND on the following cycle.
- **Single step:** step with `dbg_step_cnt` = 3, then 3 `wb_valid` pulses -> `step_remaining` goes 3, 2, 1, 0, then HALT_PEND and `halt_cause` = 3.
- **Step preemption:** step count 5; `dbg_halt_req` rises after 2 retirements -> `halt_cause` = 2, `step_remaining` = 0. Step with count 0 -> remains HALTED, no `pipe_resume`.
- **Halt-cycle counter:**
  - hold HALTED for 100 cycles -> `halt_cycles` = 100, held after resume;
  - force the counter near 0xFFFF_FFFF -> it saturates.
- **Reset mid-HALT_PEND, and simultaneous sources:**
  - `rst_n` = 0 during HALT_PEND -> state RUN and all outputs 0 next cycle;
  - simultaneous `dbg_halt_req` and `bp_stall` -> `halt_cause` = 2.
